// File: rtl/telemetry_rx.sv
// Telemetry packet receiver: parses 8-byte AA 55 framed packets from a UART byte
// stream and publishes battery voltage, average current and average torque.
module telemetry_rx #(
  parameter logic [19:0] TMO_CYCLES = 20'd200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rdy,
  output logic        clr_rdy,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_vld,
  output logic        frm_err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {IDLE, DLM2, P1, P2, P3, P4, P5, P6} state_t;

  state_t      state_q, state_d;
  logic [19:0] tmo_q, tmo_d;
  logic [3:0]  bhi_q, bhi_d, chi_q, chi_d, thi_q, thi_d;
  logic [7:0]  blo_q, blo_d, clo_q, clo_d;
  logic [11:0] batt_q, batt_d, curr_q, curr_d, torq_q, torq_d;
  logic        vld_q, vld_d, err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        hi_ok, tmo_hit;

  // Every presented byte is consumed immediately, even while held in reset.
  assign clr_rdy = rdy;
  assign hi_ok   = (rx_data[7:4] == 4'h0);
  assign tmo_hit = (state_q != IDLE) && (tmo_q == TMO_CYCLES - 20'd1);

  always_comb begin
    state_d = state_q;
    tmo_d   = (state_q == IDLE) ? 20'd0 : tmo_q + 20'd1;
    bhi_d   = bhi_q;
    blo_d   = blo_q;
    chi_d   = chi_q;
    clo_d   = clo_q;
    thi_d   = thi_q;
    batt_d  = batt_q;
    curr_d  = curr_q;
    torq_d  = torq_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (rdy) begin
      // An accepted byte always wins over a coincident timeout.
      tmo_d = 20'd0;
      case (state_q)
        IDLE: if (rx_data == 8'hAA) state_d = DLM2;
        DLM2: begin
          if (rx_data == 8'h55)      state_d = P1;
          else if (rx_data != 8'hAA) begin state_d = IDLE; err_d = 1'b1; end
        end
        P1: if (hi_ok) begin bhi_d = rx_data[3:0]; state_d = P2; end
            else begin state_d = IDLE; err_d = 1'b1; end
        P2: begin blo_d = rx_data; state_d = P3; end
        P3: if (hi_ok) begin chi_d = rx_data[3:0]; state_d = P4; end
            else begin state_d = IDLE; err_d = 1'b1; end
        P4: begin clo_d = rx_data; state_d = P5; end
        P5: if (hi_ok) begin thi_d = rx_data[3:0]; state_d = P6; end
            else begin state_d = IDLE; err_d = 1'b1; end
        P6: begin
          batt_d  = {bhi_q, blo_q};
          curr_d  = {chi_q, clo_q};
          torq_d  = {thi_q, rx_data};
          vld_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = IDLE;
      tmo_d   = 20'd0;
      err_d   = 1'b1;
    end
    if (err_d && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmo_q   <= 20'd0;
      bhi_q   <= 4'h0;
      blo_q   <= 8'h00;
      chi_q   <= 4'h0;
      clo_q   <= 8'h00;
      thi_q   <= 4'h0;
      batt_q  <= 12'h000;
      curr_q  <= 12'h000;
      torq_q  <= 12'h000;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      bhi_q   <= bhi_d;
      blo_q   <= blo_d;
      chi_q   <= chi_d;
      clo_q   <= clo_d;
      thi_q   <= thi_d;
      batt_q  <= batt_d;
      curr_q  <= curr_d;
      torq_q  <= torq_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign batt_v     = batt_q;
  assign avg_curr   = curr_q;
  assign avg_torque = torq_q;
  assign pkt_vld    = vld_q;
  assign frm_err    = err_q;
  assign err_cnt    = cnt_q;

endmodule
